// File: rtl/bd4_rr_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bd4_rr_channel_arbiter
// Purpose  : Round-robin merge of N 4-phase bundled-data input channels onto
//            a single 4-phase bundled-data output channel.
// Config   : BD_ARB_SYNC_EN - 2-flop synchronizers on in_req and out_ack.
// Revision : 1.0 - initial release
// ============================================================================
module bd4_rr_channel_arbiter #(
   parameter int  N     = 4,
   parameter int  WIDTH = 8,
   localparam int IDW   = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       in_req,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ack,
   output logic               out_req,
   output logic [WIDTH-1:0]   out_data,
   input  logic               out_ack,
   output logic [IDW-1:0]     grant_id,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_ACK  = 2'd2,
      S_REL  = 2'd3
   } state_t;

   localparam logic [IDW:0]   c_N       = (IDW+1)'(N);
   localparam logic [IDW-1:0] c_PTR_RST = IDW'(N-1);

   logic [N-1:0] w_in_req;
   logic         w_out_ack;

`ifdef BD_ARB_SYNC_EN
   logic [N-1:0] r_req_s1;
   logic [N-1:0] r_req_s2;
   logic         r_ack_s1;
   logic         r_ack_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_s1 <= '0;
         r_req_s2 <= '0;
         r_ack_s1 <= 1'b0;
         r_ack_s2 <= 1'b0;
      end else begin
         r_req_s1 <= in_req;
         r_req_s2 <= r_req_s1;
         r_ack_s1 <= out_ack;
         r_ack_s2 <= r_ack_s1;
      end
   end

   assign w_in_req  = r_req_s2;
   assign w_out_ack = r_ack_s2;
`else
   assign w_in_req  = in_req;
   assign w_out_ack = out_ack;
`endif

   logic [WIDTH-1:0] w_chan_data [N];

   generate
      for (genvar g = 0; g < N; g++) begin : g_unpack
         assign w_chan_data[g] = in_data[g*WIDTH +: WIDTH];
      end
   endgenerate

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N-1:0]     r_in_ack;
   logic [N-1:0]     w_in_ack_nxt;
   logic             r_out_req;
   logic             w_out_req_nxt;
   logic [WIDTH-1:0] r_out_data;
   logic [WIDTH-1:0] w_out_data_nxt;
   logic [IDW-1:0]   r_grant_id;
   logic [IDW-1:0]   w_grant_id_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic [IDW-1:0]   r_rr_ptr;
   logic [IDW-1:0]   w_rr_ptr_nxt;

   // Search starts just after the last served channel, wrapping modulo N.
   logic [IDW:0]     w_idx;
   logic [IDW-1:0]   w_win;
   logic             w_found;

   always_comb begin
      w_idx   = '0;
      w_win   = '0;
      w_found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
         if (w_idx >= c_N) begin
            w_idx = w_idx - c_N;
         end
         if (!w_found && w_in_req[w_idx[IDW-1:0]]) begin
            w_win   = w_idx[IDW-1:0];
            w_found = 1'b1;
         end
      end
   end

   logic [N-1:0] w_grant_oh;
   assign w_grant_oh = {{(N-1){1'b0}}, 1'b1} << r_grant_id;

   always_comb begin
      w_state_nxt    = r_state;
      w_in_ack_nxt   = r_in_ack;
      w_out_req_nxt  = r_out_req;
      w_out_data_nxt = r_out_data;
      w_grant_id_nxt = r_grant_id;
      w_busy_nxt     = r_busy;
      w_rr_ptr_nxt   = r_rr_ptr;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_out_data_nxt = w_chan_data[w_win];
               w_grant_id_nxt = w_win;
               w_out_req_nxt  = 1'b1;
               w_busy_nxt     = 1'b1;
               w_state_nxt    = S_REQ;
            end
         end
         S_REQ: begin
            if (w_out_ack) begin
               w_in_ack_nxt = w_grant_oh;
               w_state_nxt  = S_ACK;
            end
         end
         S_ACK: begin
            // A requester that withdrew early still sees this exit at once.
            if (!w_in_req[r_grant_id]) begin
               w_out_req_nxt = 1'b0;
               w_state_nxt   = S_REL;
            end
         end
         S_REL: begin
            if (!w_out_ack) begin
               w_in_ack_nxt = '0;
               w_rr_ptr_nxt = r_grant_id;
               w_busy_nxt   = 1'b0;
               w_state_nxt  = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_in_ack   <= '0;
         r_out_req  <= 1'b0;
         r_out_data <= '0;
         r_grant_id <= '0;
         r_busy     <= 1'b0;
         r_rr_ptr   <= c_PTR_RST;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ack   <= w_in_ack_nxt;
         r_out_req  <= w_out_req_nxt;
         r_out_data <= w_out_data_nxt;
         r_grant_id <= w_grant_id_nxt;
         r_busy     <= w_busy_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
      end
   end

   assign in_ack   = r_in_ack;
   assign out_req  = r_out_req;
   assign out_data = r_out_data;
   assign grant_id = r_grant_id;
   assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bd4_rr_channel_arbiter.sv
`default_nettype none
// Scoreboard bench for bd4_rr_channel_arbiter: 4-phase producer/consumer
// models drive the DUT, a monitor pops expected grants as out_req rises.
module tb_bd4_rr_channel_arbiter;

   localparam int N = 4;
   localparam int W = 8;
`ifdef BD_ARB_SYNC_EN
   localparam int EXP_LAT = 3;
   localparam int EXP_CYC = 12;
`else
   localparam int EXP_LAT = 1;
   localparam int EXP_CYC = 4;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   in_req;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ack;
   logic           out_req;
   logic [W-1:0]   out_data;
   logic           out_ack;
   logic [1:0]     grant_id;
   logic           busy;

   bd4_rr_channel_arbiter #(.N(N), .WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_req   (in_req),
      .in_data  (in_data),
      .in_ack   (in_ack),
      .out_req  (out_req),
      .out_data (out_data),
      .out_ack  (out_ack),
      .grant_id (grant_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cnt [N];
   int   ack_dly = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int id, input logic [7:0] d);
      exp_t e;
      e.id   = 2'(id);
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic set_data(input int ch, input logic [7:0] d);
      in_data[ch*W +: W] = d;
   endtask

   function automatic bit pending();
      bit p = 1'b0;
      for (int i = 0; i < N; i++) if (cnt[i] != 0) p = 1'b1;
      return p;
   endfunction

   task automatic wait_idle(input string tag);
      int n = 0;
      do begin
         @(negedge clk); #2;
         n++;
      end while (n < 600 && (pending() || in_req != 0 || in_ack != 0 || busy || out_ack));
      if (n >= 600) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout waiting for idle, got busy=%0b expected idle", tag, busy);
      end
   endtask

   // Producers (one per channel) and the downstream consumer, acting mid-cycle.
   initial begin
      int dcnt = 0;
      forever begin
         @(negedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (in_req[i] && in_ack[i]) begin
               in_req[i] = 1'b0;
               cnt[i]    = cnt[i] - 1;
            end else if (!in_req[i] && !in_ack[i] && cnt[i] > 0) begin
               in_req[i] = 1'b1;
            end
         end
         if (out_req != out_ack) begin
            if (dcnt >= ack_dly) begin
               out_ack = out_req;
               dcnt    = 0;
            end else begin
               dcnt++;
            end
         end else begin
            dcnt = 0;
         end
      end
   end

   // Monitor: grant contents, data stability and 4-phase edge ordering.
   initial begin
      logic       p_req = 1'b0;
      logic [3:0] p_ack = '0;
      logic [7:0] p_data = '0;
      logic [1:0] cur_id = '0;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            p_req = 1'b0;
            p_ack = '0;
            continue;
         end
         if (out_req && !p_req) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_grant: got grant_id=%0d expected none", grant_id);
            end else begin
               e      = sb.pop_front();
               cur_id = e.id;
               chk("grant_id", 32'(grant_id), 32'(e.id));
               chk("out_data", 32'(out_data), 32'(e.data));
               chk("busy_on_grant", 32'(busy), 32'd1);
            end
         end
         if (out_req && p_req) chk("out_data_stable", 32'(out_data), 32'(p_data));
         if (in_ack != 0 || p_ack != 0) chk("in_ack_only_winner", 32'(in_ack & ~(4'b0001 << cur_id)), 32'd0);
         if (in_ack != 0 && p_ack == 0) begin
            chk("in_ack_onehot", 32'(in_ack), 32'(4'b0001 << cur_id));
            chk("in_ack_after_out_ack", 32'(out_ack), 32'd1);
         end
         if (!out_req && p_req) chk("out_req_fall_after_in_req_low", 32'(in_req[cur_id]), 32'd0);
         if (in_ack == 0 && p_ack != 0) chk("in_ack_fall_after_release", 32'({out_req, out_ack}), 32'd0);
         p_req  = out_req;
         p_ack  = in_ack;
         p_data = out_data;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int t_req;
      bit seen;
      rst_n   = 1'b0;
      in_req  = '0;
      in_data = '0;
      out_ack = 1'b0;
      for (int i = 0; i < N; i++) cnt[i] = 0;

      // 1: requests held through reset, then order 0,1,2,3,0
      set_data(0, 8'h11); set_data(1, 8'h22); set_data(2, 8'h33); set_data(3, 8'h44);
      cnt[0] = 2; cnt[1] = 1; cnt[2] = 1; cnt[3] = 1;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_in_ack", 32'(in_ack), 32'd0);
      chk("rst_out_req", 32'(out_req), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11);
      @(negedge clk);
      rst_n = 1'b1;
      wait_idle("t1");

      // 2: single channel 2, latency and transfer length
      set_data(2, 8'hA5);
      push(2, 8'hA5);
      @(posedge clk); #1;
      cnt[2] = 1;
      @(negedge clk); #2;
      n = 0; t_req = 0; seen = 1'b0;
      while (n < 100) begin
         @(posedge clk); #1;
         n++;
         if (out_req && t_req == 0) t_req = n;
         if (busy) seen = 1'b1;
         else if (seen) break;
      end
      chk("req_latency", 32'(t_req), 32'(EXP_LAT));
      chk("xfer_cycles", 32'(n), 32'(EXP_CYC));
      chk("t2_grant_id_hold", 32'(grant_id), 32'd2);
      wait_idle("t2");

      // 3: wrap-around after serving channel 3
      set_data(3, 8'hC3);
      push(3, 8'hC3);
      cnt[3] = 1;
      wait_idle("t3a");
      set_data(0, 8'h0F);
      push(0, 8'h0F); push(3, 8'hC3);
      cnt[0] = 1; cnt[3] = 1;
      wait_idle("t3b");

      // 4: slow downstream, two contenders
      ack_dly = 5;
      set_data(1, 8'h5A); set_data(2, 8'h96);
      push(1, 8'h5A); push(2, 8'h96);
      cnt[1] = 1; cnt[2] = 1;
      wait_idle("t4");
      ack_dly = 0;

      // 5: reset while in ACK, then priority restarts at channel 0
      set_data(3, 8'hE7);
      push(3, 8'hE7);
      cnt[3] = 1;
      n = 0;
      while (!in_ack[3] && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t5_reached_ack", 32'(in_ack), 32'h8);
      rst_n   = 1'b0;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      in_req  = '0;
      out_ack = 1'b0;
      #1;
      chk("t5_rst_in_ack", 32'(in_ack), 32'd0);
      chk("t5_rst_out_req", 32'(out_req), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_grant_id", 32'(grant_id), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      set_data(0, 8'h10); set_data(1, 8'h20); set_data(2, 8'h30); set_data(3, 8'h40);
      push(0, 8'h10); push(1, 8'h20); push(2, 8'h30); push(3, 8'h40);
      for (int i = 0; i < N; i++) cnt[i] = 1;
      wait_idle("t5");

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
